// File: rtl/cpu_muldiv_if.sv
// rtl/cpu_muldiv_if.sv - function codes and ALU-to-muldiv request/result interface (optional MULDIV_ABORT_EN)
package cpu_muldiv_pkg;
    typedef enum logic [5:0] {
        FUNC_MTHI  = 6'h11,
        FUNC_MTLO  = 6'h13,
        FUNC_MULT  = 6'h18,
        FUNC_MULTU = 6'h19,
        FUNC_DIV   = 6'h1a,
        FUNC_DIVU  = 6'h1b
    } func_t;
endpackage

interface cpu_muldiv_if #(parameter int WIDTH = 32);
    import cpu_muldiv_pkg::*;

    logic             start_i;
    func_t            funct_i;
    logic [WIDTH-1:0] rs_i;
    logic [WIDTH-1:0] rt_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;
`ifdef MULDIV_ABORT_EN
    logic             abort_i;
`endif

    modport master (
`ifdef MULDIV_ABORT_EN
        output abort_i,
`endif
        output start_i, funct_i, rs_i, rt_i,
        input  busy_o, done_o, hi_o, lo_o
    );

    modport slave (
`ifdef MULDIV_ABORT_EN
        input  abort_i,
`endif
        input  start_i, funct_i, rs_i, rt_i,
        output busy_o, done_o, hi_o, lo_o
    );
endinterface

// File: rtl/cpu_muldiv.sv
// rtl/cpu_muldiv.sv - multi-cycle shift-add multiplier / restoring divider owning HI/LO (optional MULDIV_ABORT_EN)
module cpu_muldiv
    import cpu_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    cpu_muldiv_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic                 neg_q, neg_d;
    logic                 rneg_q, rneg_d;
    logic                 is_div_q, is_div_d;
    logic                 dz_q, dz_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;

    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_trial;
    logic [WIDTH:0]       div_diff;
    logic                 signed_op;
    logic [WIDTH-1:0]     abs_rs;
    logic [WIDTH-1:0]     abs_rt;
    logic [WIDTH-1:0]     lo_fix;
    logic [WIDTH-1:0]     hi_fix;

    // Next-state, datapath iteration and HI/LO commit
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        b_d      = b_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        is_div_d = is_div_q;
        dz_d     = dz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, b_q};
        div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff  = div_trial - {1'b0, b_q};
        signed_op = (bus.funct_i == FUNC_MULT) || (bus.funct_i == FUNC_DIV);
        abs_rs    = (signed_op && bus.rs_i[WIDTH-1]) ? -bus.rs_i : bus.rs_i;
        abs_rt    = (signed_op && bus.rt_i[WIDTH-1]) ? -bus.rt_i : bus.rt_i;
        lo_fix    = neg_q  ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
        hi_fix    = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

        case (state_q)
            S_IDLE: begin
                if (dz_q) begin
                    // Divide by zero accepted last edge: commit zeros without going busy
                    hi_d   = '0;
                    lo_d   = '0;
                    done_d = 1'b1;
                    dz_d   = 1'b0;
                end else if (bus.start_i) begin
                    case (bus.funct_i)
                        FUNC_MULT, FUNC_MULTU: begin
                            acc_d    = {{WIDTH{1'b0}}, abs_rs};
                            b_d      = abs_rt;
                            neg_d    = signed_op && (bus.rs_i[WIDTH-1] ^ bus.rt_i[WIDTH-1]);
                            rneg_d   = 1'b0;
                            is_div_d = 1'b0;
                            cnt_d    = '0;
                            state_d  = S_MUL;
                        end
                        FUNC_DIV, FUNC_DIVU: begin
                            if (bus.rt_i == '0) begin
                                dz_d = 1'b1;
                            end else begin
                                acc_d    = {{WIDTH{1'b0}}, abs_rs};
                                b_d      = abs_rt;
                                neg_d    = signed_op && (bus.rs_i[WIDTH-1] ^ bus.rt_i[WIDTH-1]);
                                rneg_d   = signed_op && bus.rs_i[WIDTH-1];
                                is_div_d = 1'b1;
                                cnt_d    = '0;
                                state_d  = S_DIV;
                            end
                        end
                        FUNC_MTHI: begin
                            hi_d   = bus.rs_i;
                            done_d = 1'b1;
                        end
                        FUNC_MTLO: begin
                            lo_d   = bus.rs_i;
                            done_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                // Add multiplicand into the upper half when the low bit is set, then shift right
                if (acc_q[0]) begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end else begin
                    acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    cnt_d   = '0;
                    state_d = S_FIX;
                end
            end
            S_DIV: begin
                // Upper half is the partial remainder, lower half shifts dividend out / quotient in
                if (!div_diff[WIDTH]) begin
                    acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    cnt_d   = '0;
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                // First edge applies sign correction, second edge commits
                if (cnt_q == '0) begin
                    cnt_d = 1;
                    if (is_div_q) begin
                        acc_d = {hi_fix, lo_fix};
                    end else if (neg_q) begin
                        acc_d = -acc_q;
                    end
                end else begin
                    hi_d    = acc_q[2*WIDTH-1:WIDTH];
                    lo_d    = acc_q[WIDTH-1:0];
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef MULDIV_ABORT_EN
        // Abort wins over everything in a busy state, including the commit edge
        if (state_q != S_IDLE && bus.abort_i) begin
            state_d = S_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
            done_d  = 1'b0;
        end
`endif
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            b_q      <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            is_div_q <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            b_q      <= b_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            is_div_q <= is_div_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy_o = (state_q != S_IDLE);
    assign bus.done_o = done_q;
    assign bus.hi_o   = hi_q;
    assign bus.lo_o   = lo_q;
endmodule

// File: tb/tb_cpu_muldiv.sv
// tb/tb_cpu_muldiv.sv - self-checking bench for cpu_muldiv against an arithmetic reference model
module tb_cpu_muldiv;
    import cpu_muldiv_pkg::*;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    cpu_muldiv_if #(.WIDTH(32)) bus ();

    cpu_muldiv #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model(input func_t f, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        h = '0;
        l = '0;
        case (f)
            FUNC_MULT: begin
                p = 64'(sa * sb);
                h = p[63:32];
                l = p[31:0];
            end
            FUNC_MULTU: begin
                p = 64'(a) * 64'(b);
                h = p[63:32];
                l = p[31:0];
            end
            FUNC_DIV: begin
                if (b != 0) begin
                    q = sa / sb;
                    r = sa % sb;
                    h = r[31:0];
                    l = q[31:0];
                end
            end
            FUNC_DIVU: begin
                if (b != 0) begin
                    h = a % b;
                    l = a / b;
                end
            end
            default: ;
        endcase
    endfunction

    task automatic do_long(input func_t f, input logic [31:0] a, input logic [31:0] b,
                           input bit inject, input string tag);
        logic [31:0] eh, el, ph, pl;
        model(f, a, b, eh, el);
        ph = bus.hi_o;
        pl = bus.lo_o;
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.funct_i = f;
        bus.rs_i    = a;
        bus.rt_i    = b;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        bus.rs_i    = $urandom;
        bus.rt_i    = $urandom;
        chk({tag, ":busy_e0"}, 64'(bus.busy_o), 64'd1);
        if (inject) begin
            bus.start_i = 1'b1;
            bus.funct_i = FUNC_MTHI;
            bus.rs_i    = 32'hDEADBEEF;
            repeat (3) @(posedge clk);
            #1;
            bus.start_i = 1'b0;
            repeat (30) @(posedge clk);
        end else begin
            repeat (33) @(posedge clk);
        end
        #1;
        chk({tag, ":busy_e33"}, 64'(bus.busy_o), 64'd1);
        chk({tag, ":hold_e33"}, {bus.hi_o, bus.lo_o}, {ph, pl});
        chk({tag, ":nodone_e33"}, 64'(bus.done_o), 64'd0);
        @(posedge clk); #1;
        chk({tag, ":done_e34"}, 64'(bus.done_o), 64'd1);
        chk({tag, ":idle_e34"}, 64'(bus.busy_o), 64'd0);
        chk({tag, ":hilo"}, {bus.hi_o, bus.lo_o}, {eh, el});
        @(posedge clk); #1;
        chk({tag, ":pulse_end"}, 64'(bus.done_o), 64'd0);
    endtask

    task automatic do_dz(input func_t f, input logic [31:0] a, input string tag);
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.funct_i = f;
        bus.rs_i    = a;
        bus.rt_i    = '0;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        chk({tag, ":busy_e0"}, 64'(bus.busy_o), 64'd0);
        chk({tag, ":nodone_e0"}, 64'(bus.done_o), 64'd0);
        @(posedge clk); #1;
        chk({tag, ":done_e1"}, 64'(bus.done_o), 64'd1);
        chk({tag, ":busy_e1"}, 64'(bus.busy_o), 64'd0);
        chk({tag, ":hilo"}, {bus.hi_o, bus.lo_o}, 64'd0);
        @(posedge clk); #1;
        chk({tag, ":pulse_end"}, 64'(bus.done_o), 64'd0);
    endtask

    task automatic do_mt(input func_t f, input logic [31:0] a, input string tag);
        logic [31:0] eh, el;
        eh = (f == FUNC_MTHI) ? a : bus.hi_o;
        el = (f == FUNC_MTLO) ? a : bus.lo_o;
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.funct_i = f;
        bus.rs_i    = a;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        chk({tag, ":done"}, 64'(bus.done_o), 64'd1);
        chk({tag, ":busy"}, 64'(bus.busy_o), 64'd0);
        chk({tag, ":hilo"}, {bus.hi_o, bus.lo_o}, {eh, el});
    endtask

    task automatic start_divu_run10(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.funct_i = FUNC_DIVU;
        bus.rs_i    = a;
        bus.rt_i    = b;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] ph, pl, ra, rb;
        int          done_cnt;
        int          op;
        total = 0;
        bad   = 0;
        rst_n       = 1'b0;
        bus.start_i = 1'b0;
        bus.funct_i = FUNC_MTHI;
        bus.rs_i    = '0;
        bus.rt_i    = '0;
`ifdef MULDIV_ABORT_EN
        bus.abort_i = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", 64'(bus.busy_o), 64'd0);
        chk("reset_done", 64'(bus.done_o), 64'd0);
        chk("reset_hilo", {bus.hi_o, bus.lo_o}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_long(FUNC_MULT,  32'hFFFFFFFD, 32'd7,        1'b0, "mult_neg3x7");
        do_long(FUNC_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "multu_max");
        do_long(FUNC_DIV,   32'hFFFFFFF9, 32'd2,        1'b0, "div_neg7by2");
        do_long(FUNC_DIV,   32'h80000000, 32'hFFFFFFFF, 1'b0, "div_wrap");
        do_dz(FUNC_DIVU, 32'd7, "divu_by0");
        do_mt(FUNC_MTHI, 32'h12345678, "mthi");
        do_mt(FUNC_MTLO, 32'hCAFEBABE, "mtlo");
        do_long(FUNC_MULT, 32'h00001234, 32'hFFFF0001, 1'b1, "mthi_during_busy");

        ph = bus.hi_o;
        pl = bus.lo_o;
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.funct_i = func_t'(6'h20);
        bus.rs_i    = 32'h55555555;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        chk("unsup_busy", 64'(bus.busy_o), 64'd0);
        chk("unsup_done", 64'(bus.done_o), 64'd0);
        @(posedge clk); #1;
        chk("unsup_done2", 64'(bus.done_o), 64'd0);
        chk("unsup_hilo", {bus.hi_o, bus.lo_o}, {ph, pl});

        for (int i = 0; i < 16; i++) begin
            op = $urandom_range(0, 3);
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if (op == 2 && rb == 0) begin
                do_dz(FUNC_DIV, ra, "rand_div0");
            end else if (op == 3 && rb == 0) begin
                do_dz(FUNC_DIVU, ra, "rand_divu0");
            end else begin
                case (op)
                    0: do_long(FUNC_MULT,  ra, rb, 1'b0, "rand_mult");
                    1: do_long(FUNC_MULTU, ra, rb, 1'b0, "rand_multu");
                    2: do_long(FUNC_DIV,   ra, rb, 1'b0, "rand_div");
                    default: do_long(FUNC_DIVU, ra, rb, 1'b0, "rand_divu");
                endcase
            end
        end

`ifdef MULDIV_ABORT_EN
        do_mt(FUNC_MTHI, 32'h11111111, "pre_abort_hi");
        do_mt(FUNC_MTLO, 32'h22222222, "pre_abort_lo");
        start_divu_run10(32'd1000, 32'd3);
        bus.abort_i = 1'b1;
        @(posedge clk); #1;
        bus.abort_i = 1'b0;
        chk("abort_busy", 64'(bus.busy_o), 64'd0);
        chk("abort_hilo", {bus.hi_o, bus.lo_o}, {32'h11111111, 32'h22222222});
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.done_o) done_cnt++;
        end
        chk("abort_nodone", 64'(done_cnt), 64'd0);
        chk("abort_hilo_later", {bus.hi_o, bus.lo_o}, {32'h11111111, 32'h22222222});
`endif

        do_mt(FUNC_MTHI, 32'hA5A5A5A5, "pre_rst_hi");
        start_divu_run10(32'd1000, 32'd3);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_busy", 64'(bus.busy_o), 64'd0);
        chk("rst_mid_done", 64'(bus.done_o), 64'd0);
        chk("rst_mid_hilo", {bus.hi_o, bus.lo_o}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.done_o) done_cnt++;
        end
        chk("rst_mid_nodone", 64'(done_cnt), 64'd0);
        chk("rst_mid_hilo_later", {bus.hi_o, bus.lo_o}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cpu_muldiv.md
Name: cpu_muldiv

Overview:
Multi-cycle multiply/divide unit that owns the HI/LO register pair and responds to mult/div/move requests issued by the ALU stage.
Replaces single-cycle HI/LO arithmetic with a shift-add multiplier and a restoring divider (1 bit/cycle).
Exposes busy/done handshake so the pipeline stalls MFHI/MFLO until results commit.
HI/LO outputs are read directly by the MFHI/MFLO datapath.

Parameters:
WIDTH, 32, operand/HI/LO width; iteration count equals WIDTH.

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
start_i  input  1  request strobe, sampled only when busy_o=0
funct_i  input  func_t  operation: FUNC_MULT, FUNC_MULTU, FUNC_DIV, FUNC_DIVU, FUNC_MTHI, FUNC_MTLO; other codes ignored
rs_i  input  WIDTH  operand A / dividend / MTHI,MTLO source
rt_i  input  WIDTH  operand B / divisor
busy_o  output  1  operation in progress; new requests ignored
done_o  output  1  one-cycle pulse on the cycle HI/LO commit
hi_o  output  WIDTH  HI register
lo_o  output  WIDTH  LO register

Behaviour:
- Reset (rst_n=0 at an edge, including mid-operation): state IDLE, hi_o=0, lo_o=0, busy_o=0, done_o=0; in-flight operation discarded.
- States: IDLE, MUL, DIV, FIX.
- IDLE + start_i + MULT/MULTU/DIV/DIVU at edge E0: rs_i/rt_i captured (later changes have no effect), busy_o=1 after E0.
- Signed ops: magnitudes |rs|,|rt| used; FIX negates product if signs differ; quotient negated if signs differ; remainder takes dividend sign (truncating division).
- MUL: 64-bit accumulator, one shift-add per cycle, WIDTH cycles (E1..E32), then FIX (E33); HI=product[63:32], LO=product[31:0] commit at E34, done_o=1 for the cycle after E34, busy_o=0 after E34. Total: 34 edges start-to-commit.
- DIV: restoring, one quotient bit per cycle, same 34-edge latency; LO=quotient, HI=remainder.
- Divide by zero (rt_i=0, DIV or DIVU): no iteration; HI=0, LO=0 commit at E1, done_o pulse after E1, busy_o never asserted.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (wrap, no trap).
- MTHI: HI<=rs_i at E0, LO unchanged; MTLO: LO<=rs_i at E0, HI unchanged; done_o pulse after E0; busy_o stays 0.
- start_i while busy_o=1: ignored (no queue, no error); HI/LO unchanged until current op commits.
- start_i with unsupported funct_i: ignored, no done_o.
- HI/LO hold previous values throughout MUL/DIV; they change only at commit.
- done_o and commit never coincide with acceptance of a new op; a new start_i is accepted at the edge after the commit edge.

Optional Feature:
MULDIV_ABORT_EN: adds input abort_i (1 bit). When defined, abort_i=1 at an edge while busy_o=1 returns to IDLE, HI/LO unchanged, no done_o, busy_o=0 after that edge; abort_i at the commit edge takes priority (no commit). abort_i in IDLE has no effect, including on a simultaneous start_i (start still accepted). When undefined, no abort_i port exists and operations always run to completion or reset.

Test Plan:
MULT rs=0xFFFFFFFD (-3), rt=7 -> busy 34 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFEB, single done_o pulse.
MULTU rs=rt=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001 at E0+34.
DIV rs=0xFFFFFFF9 (-7), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; then DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
DIVU rs=7, rt=0 -> HI=0, LO=0, done_o after E1, busy_o never high.
MTHI 0x12345678 then MTLO 0xCAFEBABE -> HI=0x12345678, LO=0xCAFEBABE; MTHI 0xDEADBEEF issued during busy MULT -> ignored, MULT result committed.
rst_n=0 at E0+10 of a DIVU -> hi_o=lo_o=0, busy_o=0, no done_o; with MULDIV_ABORT_EN, abort_i at E0+10 -> prior HI/LO retained, no done_o.
